// File: rtl/stream_mux_rr_if.sv
// Valid/ready bundle for the N-to-1 stream mux: per-channel inputs, one registered output.
// master = source/consumer side, slave = mux side.
interface stream_mux_rr_if #(
  parameter int NUM_IN = 32,
  parameter int DATA_W = 2,
  parameter int SEL_W  = 5
);
  logic                     mode;
  logic [SEL_W-1:0]         sel;
  logic [NUM_IN*DATA_W-1:0] in_data;
  logic [NUM_IN-1:0]        in_valid;
  logic [NUM_IN-1:0]        in_ready;
  logic [DATA_W-1:0]        out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [SEL_W-1:0]         out_src;
  logic                     sel_err;

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_src, sel_err
  );

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_src, sel_err
  );
endinterface

// File: rtl/stream_mux_rr.sv
// N-to-1 valid/ready stream mux with one registered output stage.
// Channel choice is either directed by sel or round-robin over the valid channels.
module stream_mux_rr #(
  parameter int NUM_IN = 32,
  parameter int DATA_W = 2,
  parameter int SEL_W  = 5
) (
  input  logic           clk,
  input  logic           reset,
  stream_mux_rr_if.slave bus
);

  logic [SEL_W-1:0]  rr_last;
  logic [NUM_IN-1:0] upper_req;
  logic [SEL_W-1:0]  upper_idx;
  logic [SEL_W-1:0]  lower_idx;
  logic [SEL_W-1:0]  rr_idx;
  logic              dir_vld;
  logic              sel_in_range;
  logic              grant_vld;
  logic [SEL_W-1:0]  grant_idx;
  logic [DATA_W-1:0] grant_data;
  logic              load_en;
  logic [NUM_IN-1:0] ready_d;

  logic [DATA_W-1:0] out_data_q;
  logic [SEL_W-1:0]  out_src_q;
  logic              out_valid_q;
  logic              sel_err_q;

  // Compare with one extra bit so NUM_IN == 2**SEL_W does not wrap to zero.
  assign sel_in_range = ({1'b0, bus.sel} < (SEL_W+1)'(NUM_IN));
  assign load_en      = ~out_valid_q | bus.out_ready;

  // Round-robin: lowest valid channel above rr_last wins, otherwise wrap to the lowest valid overall.
  always_comb begin
    upper_req = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      upper_req[i] = bus.in_valid[i] & (SEL_W'(i) > rr_last);
    end
  end

  always_comb begin
    upper_idx = '0;
    lower_idx = '0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (upper_req[i]) upper_idx = SEL_W'(i);
      if (bus.in_valid[i]) lower_idx = SEL_W'(i);
    end
  end

  assign rr_idx = (|upper_req) ? upper_idx : lower_idx;

  always_comb begin
    dir_vld = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (bus.sel == SEL_W'(i)) dir_vld = bus.in_valid[i];
    end
  end

  always_comb begin
    if (bus.mode) begin
      grant_vld = |bus.in_valid;
      grant_idx = rr_idx;
    end else begin
      grant_vld = sel_in_range & dir_vld;
      grant_idx = bus.sel;
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_idx == SEL_W'(i)) grant_data = bus.in_data[i*DATA_W +: DATA_W];
    end
  end

  // Ready is held low while in reset so no source believes a beat was taken.
  always_comb begin
    ready_d = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      ready_d[i] = ~reset & load_en & grant_vld & (grant_idx == SEL_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      sel_err_q   <= 1'b0;
      rr_last     <= SEL_W'(NUM_IN - 1);
    end else begin
      sel_err_q <= ~bus.mode & ~sel_in_range;
      if (load_en & grant_vld) begin
        out_valid_q <= 1'b1;
        out_data_q  <= grant_data;
        out_src_q   <= grant_idx;
        rr_last     <= grant_idx;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = ready_d;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sel_err   = sel_err_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: a 32-channel instance checked through a beat scoreboard,
// plus a 20-channel instance for out-of-range select behaviour.
module tb_stream_mux_rr;
  localparam int NA = 32;
  localparam int NB = 20;
  localparam int DW = 2;
  localparam int SW = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  stream_mux_rr_if #(.NUM_IN(NA), .DATA_W(DW), .SEL_W(SW)) a ();
  stream_mux_rr_if #(.NUM_IN(NB), .DATA_W(DW), .SEL_W(SW)) b ();

  stream_mux_rr #(.NUM_IN(NA), .DATA_W(DW), .SEL_W(SW)) dut_a (.clk(clk), .reset(reset), .bus(a));
  stream_mux_rr #(.NUM_IN(NB), .DATA_W(DW), .SEL_W(SW)) dut_b (.clk(clk), .reset(reset), .bus(b));

  int nvec = 0;
  int nmis = 0;
  int exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every channel i carries i%4, so an expected beat is fully described by its source index.
  always @(negedge clk) begin : monitor
    int e;
    if (!reset && a.out_valid && a.out_ready) begin
      if (exp_q.size() == 0) begin
        nvec++;
        nmis++;
        $display("FAIL unexpected_beat: got src %0d, expected no beat (t=%0t)", a.out_src, $time);
      end else begin
        e = exp_q.pop_front();
        chk("beat_src", 64'(a.out_src), 64'(e));
        chk("beat_data", 64'(a.out_data), 64'(e % 4));
      end
    end
  end

  // One cycle of stimulus on instance a; called just after a rising edge.
  task automatic step(input logic m, input logic [SW-1:0] s, input logic [NA-1:0] v,
                      input logic ordy, input logic [NA-1:0] exp_rdy, input int exp_src,
                      input int exp_ov);
    a.mode = m;
    a.sel = s;
    a.in_valid = v;
    a.out_ready = ordy;
    if (exp_rdy != '0) exp_q.push_back(exp_src);
    @(negedge clk);
    chk("in_ready", 64'(a.in_ready), 64'(exp_rdy));
    if (exp_ov >= 0) chk("out_valid", 64'(a.out_valid), 64'(exp_ov));
    @(posedge clk);
    #1;
  endtask

  task automatic b_cycle(input logic m, input logic [SW-1:0] s, input logic [NB-1:0] exp_rdy);
    b.mode = m;
    b.sel = s;
    @(negedge clk);
    chk("b_in_ready", 64'(b.in_ready), 64'(exp_rdy));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [NA-1:0] sp;
  int sparse_seq[6] = '{3, 17, 30, 3, 17, 30};

  initial begin
    a.mode = 1'b1;
    a.sel = '0;
    a.in_valid = '1;
    a.out_ready = 1'b1;
    for (int i = 0; i < NA; i++) a.in_data[i*DW +: DW] = DW'(i % 4);
    b.mode = 1'b0;
    b.sel = '0;
    b.in_valid = '0;
    b.out_ready = 1'b1;
    for (int i = 0; i < NB; i++) b.in_data[i*DW +: DW] = DW'(i % 4);

    // reset state
    reset = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(a.in_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(a.out_valid), 64'd0);
    chk("rst_out_data", 64'(a.out_data), 64'd0);
    chk("rst_out_src", 64'(a.out_src), 64'd0);
    chk("rst_sel_err", 64'(a.sel_err), 64'd0);
    chk("rst_b_out_valid", 64'(b.out_valid), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // directed sweep sel 0..31
    for (int k = 0; k < NA; k++)
      step(1'b0, SW'(k), '1, 1'b1, NA'(1) << k, k, (k == 0) ? 0 : 1);
    step(1'b0, '0, '0, 1'b1, '0, 0, 1);
    chk("dir_sel_err", 64'(a.sel_err), 64'd0);

    // round-robin fairness from reset
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < NA + 2; k++)
      step(1'b1, '0, '1, 1'b1, NA'(1) << (k % NA), k % NA, (k == 0) ? 0 : 1);

    // sparse round-robin, no bubbles
    sp = '0;
    sp[3] = 1'b1;
    sp[17] = 1'b1;
    sp[30] = 1'b1;
    for (int k = 0; k < 6; k++)
      step(1'b1, '0, sp, 1'b1, NA'(1) << sparse_seq[k], sparse_seq[k], 1);

    // backpressure: beat from channel 30 held for 5 cycles
    for (int k = 0; k < 5; k++) begin
      step(1'b1, '0, sp, 1'b0, '0, 0, 1);
      chk("bp_out_src", 64'(a.out_src), 64'd30);
      chk("bp_out_data", 64'(a.out_data), 64'd2);
    end
    step(1'b1, '0, sp, 1'b1, NA'(1) << 3, 3, 1);
    step(1'b1, '0, sp, 1'b1, NA'(1) << 17, 17, 1);
    step(1'b1, '0, '0, 1'b1, '0, 0, 1);
    step(1'b1, '0, '0, 1'b1, '0, 0, 0);

    // reset mid-stream with a stalled beat
    step(1'b1, '0, '1, 1'b0, NA'(1) << 18, 18, 0);
    step(1'b1, '0, '1, 1'b0, '0, 0, 1);
    chk("mid_out_src", 64'(a.out_src), 64'd18);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("mid_rst_in_ready", 64'(a.in_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("mid_rst_out_valid", 64'(a.out_valid), 64'd0);
    chk("mid_rst_out_data", 64'(a.out_data), 64'd0);
    chk("mid_rst_out_src", 64'(a.out_src), 64'd0);
    reset = 1'b0;
    step(1'b1, '0, '1, 1'b1, NA'(1) << 0, 0, 0);
    step(1'b1, '0, '1, 1'b1, NA'(1) << 1, 1, 1);
    step(1'b1, '0, '0, 1'b1, '0, 0, 1);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    // out-of-range select on the 20-channel instance
    b.in_valid = '1;
    b.out_ready = 1'b1;
    b_cycle(1'b0, 5'd5, NB'(1) << 5);
    chk("b_load_valid", 64'(b.out_valid), 64'd1);
    chk("b_load_src", 64'(b.out_src), 64'd5);
    chk("b_load_data", 64'(b.out_data), 64'd1);
    chk("b_sel_err_ok", 64'(b.sel_err), 64'd0);
    b_cycle(1'b0, 5'd25, '0);
    chk("b_sel_err_25", 64'(b.sel_err), 64'd1);
    chk("b_drained", 64'(b.out_valid), 64'd0);
    chk("b_src_hold", 64'(b.out_src), 64'd5);
    b_cycle(1'b0, 5'd5, NB'(1) << 5);
    chk("b_sel_err_clear", 64'(b.sel_err), 64'd0);
    chk("b_reload_valid", 64'(b.out_valid), 64'd1);
    b_cycle(1'b0, 5'd20, '0);
    chk("b_sel_err_20", 64'(b.sel_err), 64'd1);
    b_cycle(1'b0, 5'd19, NB'(1) << 19);
    chk("b_sel_err_19", 64'(b.sel_err), 64'd0);
    chk("b_src_19", 64'(b.out_src), 64'd19);
    chk("b_data_19", 64'(b.out_data), 64'd3);
    b_cycle(1'b1, 5'd25, NB'(1) << 0);
    chk("b_rr_no_err", 64'(b.sel_err), 64'd0);
    chk("b_rr_src", 64'(b.out_src), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
